corner_list_collector: RTL and testbench

CORNER_LIST_COLLECTOR -- requirements
Module: corner_list_collector

---
 rtl/corner_list_collector.sv | 146 ++++++++++++++
 tb/tb_corner_list_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/corner_list_collector.sv
// corner_list_collector
//   Turns a raster stream of per-pixel corner flags into a FIFO of (x,y)
//   corner coordinates. It tracks the pixel position, caps the accepted
//   corners per frame, flags corners lost to a full FIFO, and pulses at
//   end of frame. Queued coordinates carry over from one frame into the next.
//
//   Optional build: define CORNER_NMS_EN to suppress a corner that lies
//   fewer than MIN_DIST pixels to the right of the previously accepted
//   corner on the same row.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   one raster-order pixel this cycle
//   corner_in    in   corner flag for that pixel
//   out_valid    out  FIFO head valid
//   out_ready    in   consumer accepts the head
//   out_x        out  head column (0 when the FIFO is empty)
//   out_y        out  head row    (0 when the FIFO is empty)
//   frame_done   out  one-cycle pulse after the last pixel of a frame
//   corner_count out  corners accepted in the current or last completed frame
//   overflow     out  sticky: a corner was dropped because the FIFO was full
module corner_list_collector #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 464,
  parameter int FIFO_DEPTH   = 64,
  parameter int MAX_CORNERS  = 255,
  parameter int MIN_DIST     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        corner_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_x,
  output logic [9:0]  out_y,
  output logic        frame_done,
  output logic [15:0] corner_count,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MIN_DIST < 0) begin : g_param_err
    $error("corner_list_collector: FIFO_DEPTH must be a power of two >= 2 and MIN_DIST >= 0");
  end

  logic [9:0]  x_q, y_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [19:0] mem_q [FIFO_DEPTH];
  logic [15:0] count_q, count_d, count_base;
  logic        ovf_q, ovf_d, ovf_base;
  logic        fdone_q;

  logic empty, full, pop, push, drop, cand, supp, room, sof, last_pix;

`ifdef CORNER_NMS_EN
  logic [9:0] last_x_q;
  logic       last_vld_q, last_vld_base;
`endif

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    // Extra MSB distinguishes full from empty when the indices match.
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = !empty && out_ready;
    room     = !full || pop;
    sof      = in_valid && (x_q == 10'd0) && (y_q == 10'd0);
    last_pix = in_valid && (x_q == 10'(IMAGE_WIDTH - 1)) &&
               (y_q == 10'(IMAGE_HEIGHT - 1));

    // Per-frame statistics hold until the next frame's first pixel arrives,
    // and are cleared before that pixel is counted.
    count_base = sof ? 16'd0 : count_q;
    ovf_base   = sof ? 1'b0  : ovf_q;

    cand = in_valid && corner_in;
`ifdef CORNER_NMS_EN
    last_vld_base = last_vld_q && !(in_valid && (x_q == 10'd0));
    supp          = last_vld_base && ((x_q - last_x_q) < 10'(MIN_DIST));
`else
    supp = 1'b0;
`endif

    push    = cand && !supp && (count_base < 16'(MAX_CORNERS)) && room;
    // Only a full FIFO marks overflow; hitting the cap drops silently.
    drop    = cand && !supp && (count_base < 16'(MAX_CORNERS)) && !room;
    count_d = count_base + 16'(push);
    ovf_d   = ovf_base | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      if (in_valid) begin
        if (x_q == 10'(IMAGE_WIDTH - 1)) begin
          x_q <= '0;
          y_q <= (y_q == 10'(IMAGE_HEIGHT - 1)) ? 10'd0 : y_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      fdone_q <= last_pix;
    end
  end

`ifdef CORNER_NMS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_x_q   <= '0;
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_x_q   <= x_q;
      last_vld_q <= 1'b1;
    end else begin
      last_vld_q <= last_vld_base;
    end
  end
`endif

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {y_q, x_q};
  end

  assign out_valid    = !empty;
  assign out_x        = empty ? 10'd0 : mem_q[rd_ptr_q[AW-1:0]][9:0];
  assign out_y        = empty ? 10'd0 : mem_q[rd_ptr_q[AW-1:0]][19:10];
  assign frame_done   = fdone_q;
  assign corner_count = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_corner_list_collector.sv
// Bench for corner_list_collector on an 8x4 image, 4-entry FIFO, cap of 5
// corners and suppression distance 3. A queue-based reference model tracks
// the expected outputs cycle by cycle; directed frames cover the key cases,
// then a randomized run with occasional mid-frame resets follows.
module tb_corner_list_collector;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int D    = 4;
  localparam int MAXC = 5;
  localparam int MD   = 3;
`ifdef CORNER_NMS_EN
  localparam bit NMS = 1'b1;
`else
  localparam bit NMS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        corner_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_x, out_y;
  logic        frame_done;
  logic [15:0] corner_count;
  logic        overflow;

  corner_list_collector #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FIFO_DEPTH(D),
    .MAX_CORNERS(MAXC), .MIN_DIST(MD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .corner_in(corner_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .frame_done(frame_done), .corner_count(corner_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: linear pixel index plus a queue of coordinates.
  typedef struct { int x; int y; } ent_t;
  ent_t q[$];
  int   pix, mcount, lastx;
  bit   movf, mfd, lastv;
  // Coordinates observed leaving the DUT (head while ready was high).
  int   got_x[$], got_y[$];

  task automatic model_reset();
    q.delete();
    pix = 0; mcount = 0; movf = 0; mfd = 0; lastv = 0; lastx = 0;
  endtask

  task automatic model_step(input bit iv, input bit cn, input bit rdy);
    bit pop, room;
    int x, y;
    pop  = (q.size() > 0) && rdy;
    room = (q.size() < D) || pop;
    if (pop) q.delete(0);
    mfd = 1'b0;
    if (iv) begin
      x = pix % W;
      y = pix / W;
      if (pix == 0) begin mcount = 0; movf = 0; end
      if (x == 0) lastv = 0;
      if (cn && !(NMS && lastv && (x - lastx) < MD) && mcount < MAXC) begin
        if (room) begin
          q.push_back('{x, y});
          mcount++;
          lastx = x;
          lastv = 1;
        end else begin
          movf = 1;
        end
      end
      mfd = (pix == W * H - 1);
      pix = (pix + 1) % (W * H);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_x", out_x, q[0].x);
      chk("out_y", out_y, q[0].y);
    end
    chk("frame_done", frame_done, mfd);
    chk("corner_count", corner_count, mcount);
    chk("overflow", overflow, movf);
  endtask

  // One clock: drive on the falling edge, check just after the rising edge.
  task automatic cyc(input bit iv, input bit cn, input bit rdy);
    @(negedge clk);
    if (out_valid && rdy) begin
      got_x.push_back(int'(out_x));
      got_y.push_back(int'(out_y));
    end
    in_valid = iv; corner_in = cn; out_ready = rdy;
    model_step(iv, cn, rdy);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; corner_in = 0; out_ready = 0;
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", corner_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1;
    got_x.delete(); got_y.delete();
  endtask

  // Feed pixels [p0..p1] with corners where cmask is set.
  task automatic feed(input int p0, input int p1, input logic [31:0] cmask, input bit rdy);
    for (int p = p0; p <= p1; p++) cyc(1'b1, cmask[p], rdy);
  endtask

  initial begin
    logic [31:0] m;

    model_reset();
    do_reset();

    // Single corner at pixel 10 -> (2,1), then frame completion.
    feed(0, 10, 32'h0000_0400, 1'b1);
    chk("s1_valid", out_valid, 1);
    chk("s1_x", out_x, 2);
    chk("s1_y", out_y, 1);
    feed(11, 31, 32'h0, 1'b1);
    chk("s1_frame_done", frame_done, 1);
    chk("s1_count", corner_count, 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("s1_fd_pulse", frame_done, 0);

    // Six corners with free-flowing output: the cap keeps five.
    do_reset();
    m = 32'h0011_1111;
    feed(0, 31, m, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("s2_emitted", got_x.size(), 5);
    chk("s2_count", corner_count, 5);
    chk("s2_overflow", overflow, 0);

    // Stalled consumer: four held, fifth dropped, then drain in order.
    do_reset();
    feed(0, 16, 32'h0001_1111, 1'b0);
    chk("s3_count", corner_count, 4);
    chk("s3_overflow", overflow, 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("s3_hold_x", out_x, 0);
    chk("s3_hold_y", out_y, 0);
    got_x.delete(); got_y.delete();
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("s3_drained", got_x.size(), 4);
    if (got_x.size() == 4) begin
      chk("s3_e0x", got_x[0], 0); chk("s3_e0y", got_y[0], 0);
      chk("s3_e1x", got_x[1], 4); chk("s3_e1y", got_y[1], 0);
      chk("s3_e2x", got_x[2], 0); chk("s3_e2y", got_y[2], 1);
      chk("s3_e3x", got_x[3], 4); chk("s3_e3y", got_y[3], 1);
    end

    // Full FIFO with a pop in the same cycle accepts the new corner.
    do_reset();
    feed(0, 15, 32'h0000_1111, 1'b0);
    feed(16, 16, 32'h0001_0000, 1'b1);
    chk("s4_overflow", overflow, 0);
    chk("s4_count", corner_count, 5);

    // Same-row corners at x=1,2,4,5.
    do_reset();
    feed(0, 7, 32'h0000_0036, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    if (NMS) begin
      chk("s5_n", got_x.size(), 2);
      if (got_x.size() == 2) begin
        chk("s5_x0", got_x[0], 1); chk("s5_x1", got_x[1], 4);
      end
    end else begin
      chk("s5_n", got_x.size(), 4);
      if (got_x.size() == 4) begin
        chk("s5_x0", got_x[0], 1); chk("s5_x1", got_x[1], 2);
        chk("s5_x2", got_x[2], 4); chk("s5_x3", got_x[3], 5);
      end
    end

    // Reset mid-frame with two entries queued.
    do_reset();
    feed(0, 16, 32'h0000_0208, 1'b0);
    chk("s6_queued", out_valid, 1);
    do_reset();
    cyc(1'b1, 1'b1, 1'b0);
    chk("s6_x", out_x, 0);
    chk("s6_y", out_y, 0);
    chk("s6_count", corner_count, 1);

    // Randomized traffic across many frames.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit iv, cn, rdy;
      if (($urandom % 600) == 0) do_reset();
      iv  = ($urandom % 4) != 0;
      cn  = ($urandom % 3) == 0;
      rdy = ((i / 64) % 3 == 2) ? (($urandom % 8) == 0) : (($urandom % 3) != 0);
      cyc(iv, cn, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
